btb_assoc_predictor: RTL

//  Parametrised N-way set-associative branch target buffer with per-entry 2-bit

---
 rtl/btb_assoc_predictor_pkg.sv | 23 ++
 rtl/btb_assoc_predictor_plru.sv | 59 +++++
 rtl/btb_assoc_predictor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_predictor_pkg.sv
// Shared types for the set-associative branch target buffer.
package btb_types;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t CTR_WEAK_T = 2'b10;
  localparam btb_ctr_t CTR_MAX    = 2'b11;
  localparam btb_ctr_t CTR_MIN    = 2'b00;

  typedef enum logic {
    BTB_IDLE,
    BTB_FLUSH
  } btb_state_t;

  localparam int unsigned BTB_STAT_W = 32;

  // Saturating 2-bit direction counter step.
  function automatic btb_ctr_t ctr_next(input btb_ctr_t c, input logic taken);
    if (taken) return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
    else       return (c == CTR_MIN) ? CTR_MIN : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_assoc_predictor_plru.sv
// Per-set tree pseudo-LRU state: one bit per internal node, 0 = victim on the left.
module btb_plru_tree
  import btb_types::*;
#(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    touch_i,
  input  logic [$clog2(SETS)-1:0] touch_idx_i,
  input  logic [$clog2(WAYS)-1:0] touch_way_i,
  input  logic [$clog2(SETS)-1:0] vic_idx_i,
  output logic [$clog2(WAYS)-1:0] victim_o
);

  localparam int unsigned LVL   = $clog2(WAYS);
  localparam int unsigned NODES = WAYS - 1;

  logic [NODES-1:0] tree_q [SETS];
  logic [NODES-1:0] row_d;
  logic [NODES-1:0] vic_row;
  int unsigned      vic_node;
  int unsigned      t_node;
  int unsigned      t_dir;

  // Follow node bits from the root down to the victim leaf.
  always_comb begin
    vic_row  = tree_q[vic_idx_i];
    vic_node = 0;
    for (int unsigned l = 0; l < LVL; l++) begin
      vic_node = 2 * vic_node + 1 + 32'((vic_row >> vic_node) & NODES'(1));
    end
    victim_o = ($clog2(WAYS))'(vic_node - NODES);
  end

  // Point every node on the touched way's path away from that way.
  always_comb begin
    row_d  = tree_q[touch_idx_i];
    t_node = 0;
    t_dir  = 0;
    for (int unsigned l = 0; l < LVL; l++) begin
      t_dir = (32'(touch_way_i) >> (LVL - 1 - l)) & 32'd1;
      if (t_dir == 0) row_d = row_d | (NODES'(1) << t_node);
      else            row_d = row_d & ~(NODES'(1) << t_node);
      t_node = 2 * t_node + 1 + t_dir;
    end
  end

  // Tree bits register; cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (touch_i) begin
      tree_q[touch_idx_i] <= row_d;
    end
  end

endmodule

// File: rtl/btb_assoc_predictor.sv
// N-way set-associative BTB with 2-bit direction counters, tree-PLRU
// replacement and a set-walking flush. Optional BTB_STATS_EN builds
// lookup/hit counters; otherwise oLookups/oHits are tied to zero.
module btb_assoc_predictor
  import btb_types::*;
#(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned SETS     = 32,
  parameter int unsigned PC_WIDTH = 16,
  parameter int unsigned ADDR_LSB = 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iFlush,
  input  logic                  iRValid,
  input  logic [PC_WIDTH-1:0]   iRPc,
  output logic                  oRHit,
  output logic                  oRTaken,
  output logic [PC_WIDTH-1:0]   oRTarget,
  input  logic                  iUpdValid,
  input  logic [PC_WIDTH-1:0]   iUpdPc,
  input  logic                  iUpdTaken,
  input  logic [PC_WIDTH-1:0]   iUpdTarget,
  output logic                  oReady,
  output logic [BTB_STAT_W-1:0] oLookups,
  output logic [BTB_STAT_W-1:0] oHits
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned TAG_W = PC_WIDTH - IDX_W - ADDR_LSB;

  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [PC_WIDTH-1:0] tgt_q [SETS][WAYS];
  btb_ctr_t         ctr_q   [SETS][WAYS];

  btb_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] r_idx, u_idx;
  logic [TAG_W-1:0] r_tag, u_tag;
  logic             r_any, u_hit, u_inv_any;
  logic [WAY_W-1:0] r_way, u_way, u_inv_way, plru_victim, wr_way;
  logic             upd_en, hit_upd, alloc;

  if (ADDR_LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{iRPc[ADDR_LSB-1:0], iUpdPc[ADDR_LSB-1:0]};
  end

  assign r_idx = iRPc[ADDR_LSB +: IDX_W];
  assign r_tag = iRPc[PC_WIDTH-1 -: TAG_W];
  assign u_idx = iUpdPc[ADDR_LSB +: IDX_W];
  assign u_tag = iUpdPc[PC_WIDTH-1 -: TAG_W];

  // Flush walker: next state and set index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      BTB_IDLE: begin
        if (iFlush) begin
          state_d = BTB_FLUSH;
          idx_d   = '0;
        end
      end
      BTB_FLUSH: begin
        if (iFlush) begin
          idx_d = '0;
        end else if (idx_q == IDX_W'(SETS - 1)) begin
          state_d = BTB_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = BTB_FLUSH;
        idx_d   = '0;
      end
    endcase
  end

  // Flush walker state register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= BTB_FLUSH;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign oReady = (state_q == BTB_IDLE);

  // Lookup tag match; lowest matching way wins.
  always_comb begin
    r_any = 1'b0;
    r_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!r_any && valid_q[r_idx][w] && (tag_q[r_idx][w] == r_tag)) begin
        r_any = 1'b1;
        r_way = WAY_W'(w);
      end
    end
  end

  assign oRHit    = iRValid & oReady & r_any;
  assign oRTaken  = oRHit & ctr_q[r_idx][r_way][1];
  assign oRTarget = oRHit ? tgt_q[r_idx][r_way] : '0;

  // Update tag match and lowest invalid way for allocation.
  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    u_inv_any = 1'b0;
    u_inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!u_hit && valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!u_inv_any && !valid_q[u_idx][w]) begin
        u_inv_any = 1'b1;
        u_inv_way = WAY_W'(w);
      end
    end
  end

  assign upd_en  = iUpdValid & oReady;
  assign hit_upd = upd_en & u_hit;
  assign alloc   = upd_en & ~u_hit & iUpdTaken;
  assign wr_way  = u_hit ? u_way : (u_inv_any ? u_inv_way : plru_victim);

  btb_plru_tree #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk_i       (iClk),
    .rst_i       (iRst),
    .touch_i     (hit_upd | alloc),
    .touch_idx_i (u_idx),
    .touch_way_i (wr_way),
    .vic_idx_i   (u_idx),
    .victim_o    (plru_victim)
  );

  // Valid bits: one whole set cleared per flush cycle, set on allocation.
  always_ff @(posedge iClk) begin
    if (state_q == BTB_FLUSH) begin
      for (int unsigned w = 0; w < WAYS; w++) valid_q[idx_q][w] <= 1'b0;
    end else if (alloc) begin
      valid_q[u_idx][wr_way] <= 1'b1;
    end
  end

  // Entry payload: allocate, or train counter/target on hit.
  always_ff @(posedge iClk) begin
    if (alloc) begin
      tag_q[u_idx][wr_way] <= u_tag;
      tgt_q[u_idx][wr_way] <= iUpdTarget;
      ctr_q[u_idx][wr_way] <= CTR_WEAK_T;
    end else if (hit_upd) begin
      ctr_q[u_idx][wr_way] <= ctr_next(ctr_q[u_idx][wr_way], iUpdTaken);
      if (iUpdTaken) tgt_q[u_idx][wr_way] <= iUpdTarget;
    end
  end

`ifdef BTB_STATS_EN
  logic [BTB_STAT_W-1:0] lookups_q, hits_q;

  // Wrapping lookup/hit counters; keep counting while flushing.
  always_ff @(posedge iClk) begin
    if (iRst || iFlush) begin
      lookups_q <= '0;
      hits_q    <= '0;
    end else begin
      if (iRValid) lookups_q <= lookups_q + 1'b1;
      if (oRHit)   hits_q    <= hits_q + 1'b1;
    end
  end

  assign oLookups = lookups_q;
  assign oHits    = hits_q;
`else
  assign oLookups = '0;
  assign oHits    = '0;
`endif

endmodule
